// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width, default FIFO depth, FSM states.
package uart_pkg;

    localparam int UART_BYTE_W        = 8;
    localparam int FEED_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_PULSE = 2'd1,
        WAIT_BUSY  = 2'd2,
        WAIT_DONE  = 2'd3
    } feed_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with occupancy counter; pointers wrap modulo DEPTH (power of two).
module uart_byte_fifo import uart_pkg::*; #(
    parameter int  DEPTH  = FEED_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [UART_BYTE_W-1:0] data_i,
    input  logic                   pop_i,
    output logic [UART_BYTE_W-1:0] head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [ADDR_W:0]        count_o
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   push_ok;
    logic                   pop_ok;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Head is read combinationally so the feeder can latch it on the pop edge.
    assign head_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains a byte FIFO into a READY/SEND UART transmitter, one byte per READY cycle.
// Optional macro UART_FEED_DROP_CNT_EN adds a saturating 8-bit dropped-write counter.
module uart_tx_feeder import uart_pkg::*; #(
    parameter int  DEPTH  = FEED_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WR_EN,
    input  logic [UART_BYTE_W-1:0] WR_DATA,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [ADDR_W:0]        COUNT,
    output logic                   OVERFLOW,
    input  logic                   TX_READY,
    output logic                   TX_SEND,
    output logic [UART_BYTE_W-1:0] TX_DATA,
    output logic                   BUSY
`ifdef UART_FEED_DROP_CNT_EN
    ,
    output logic [7:0]             DROP_CNT
`endif
);

    feed_state_e            state_q, state_d;
    logic                   tx_send_q, tx_send_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   overflow_q, overflow_d;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_BYTE_W-1:0] fifo_head;
    logic                   drop;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (WR_EN),
        .data_i  (WR_DATA),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (COUNT)
    );

    // A write against a full FIFO is lost even if a pop frees a slot on the same edge.
    assign drop       = WR_EN && fifo_full;
    assign overflow_d = overflow_q || drop;

    always_comb begin
        state_d   = state_q;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && TX_READY) begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_head;
                    tx_send_d = 1'b1;
                    state_d   = SEND_PULSE;
                end
            end
            SEND_PULSE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!TX_READY) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (TX_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            tx_send_q  <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_send_q  <= tx_send_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_FEED_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

    assign FULL     = fifo_full;
    assign EMPTY    = fifo_empty;
    assign OVERFLOW = overflow_q;
    assign TX_SEND  = tx_send_q;
    assign TX_DATA  = tx_data_q;
    assign BUSY     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; SHALL be a power of two, 4..256.
REQ-002 Parameter ADDR_W, default $clog2(DEPTH), FIFO pointer width; SHALL be derived, not overridden.
REQ-003 CLK  input  1  system clock (100 MHz).
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 WR_EN  input  1  byte-write strobe from the producer (score/event logic).
REQ-006 WR_DATA  input  8  byte to enqueue.
REQ-007 FULL  output  1  FIFO holds DEPTH bytes.
REQ-008 EMPTY  output  1  FIFO holds 0 bytes.
REQ-009 COUNT  output  ADDR_W+1  current FIFO occupancy.
REQ-010 OVERFLOW  output  1  sticky: a write was dropped.
REQ-011 TX_READY  input  1  READY from the downstream UART transmitter.
REQ-012 TX_SEND  output  1  SEND to the transmitter, one-cycle pulse.
REQ-013 TX_DATA  output  8  DATA to the transmitter, registered.
REQ-014 BUSY  output  1  high when state != IDLE or EMPTY == 0.

Function
REQ-015 A write SHALL be accepted when WR_EN=1 and FULL=0 at the same clock edge; COUNT SHALL increment on the next cycle.
REQ-016 WR_EN=1 with FULL=1 SHALL drop the byte and set OVERFLOW; this SHALL hold even if a pop occurs in the same cycle.
REQ-017 Simultaneous accepted write and pop SHALL leave COUNT unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 FSM states: IDLE, SEND_PULSE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if EMPTY=0 and TX_READY=1 -> pop the head into TX_DATA, set TX_SEND=1, go to SEND_PULSE; otherwise stay.
REQ-020 SEND_PULSE: TX_SEND SHALL be 1 for exactly this one cycle, with TX_DATA stable; then clear TX_SEND and go to WAIT_BUSY.
REQ-021 WAIT_BUSY: TX_READY=0 -> WAIT_DONE; else stay.
REQ-022 WAIT_DONE: TX_READY=1 -> IDLE; else stay.
REQ-023 TX_DATA SHALL hold its value from the pop until the next pop.
REQ-024 First TX_SEND SHALL occur 2 cycles after a write into an empty FIFO with TX_READY=1: cycle 1 sees COUNT=1, cycle 2 has TX_SEND=1.
REQ-025 Bytes SHALL reach TX_DATA in write order, with no duplication and no loss other than REQ-016 drops.

Reset
REQ-026 While RST=1 the block SHALL hold: state=IDLE, pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, TX_SEND=0, TX_DATA=8'h00, BUSY=0.
REQ-027 Reset mid-transfer SHALL discard FIFO contents; after release, the block SHALL wait in IDLE for TX_READY=1 before sending.
REQ-028 OVERFLOW SHALL clear only on reset.

Configuration
REQ-029 Macro UART_FEED_DROP_CNT_EN defined: add output DROP_CNT (8 bits, reset 0), incremented per dropped write, saturating at 255.
REQ-030 Macro UART_FEED_DROP_CNT_EN undefined: no DROP_CNT port and no counter logic; OVERFLOW behaviour is unchanged.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state typedef, UART_BYTE_W=8 and FEED_DEPTH_DEFAULT=16.
REQ-032 FIFO storage and pointers SHALL live in sub-module uart_byte_fifo (push/pop/full/empty/count); the FSM SHALL live in uart_tx_feeder.

Verification
REQ-033 Single byte: write 8'hA5 with TX_READY=1 -> TX_SEND pulse 2 cycles later, TX_DATA=8'hA5, COUNT back to 0.
REQ-034 Burst: write 8'h01..8'h05 back-to-back with a transmitter model (READY low 10 cycles after SEND) -> five TX_SEND pulses, data in order 01..05, each pulse only after READY returns high.
REQ-035 Overflow: DEPTH=16, TX_READY held 0, 17 writes -> FULL=1, COUNT=16, OVERFLOW=1, DROP_CNT=1 when the macro is defined, and the 17th byte is never sent.
REQ-036 Full with pop: FULL=1, TX_READY rises, WR_EN in the pop cycle -> the write is dropped and COUNT=15.
REQ-037 Reset mid-transfer: assert RST in WAIT_DONE with COUNT=3 -> all outputs at reset values immediately, and no TX_SEND after release until a new write.
REQ-038 Saturation (macro defined): 300 dropped writes -> DROP_CNT=255.
